// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite slave around a byte-addressable single-port SRAM.
// Zero wait states, always OKAY; address phase is registered and the
// data phase follows in the next cycle.
module ahb3lite_sram_slave #(
   parameter int MEM_SIZE   = 4096,
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [HADDR_SIZE-1:0] HADDR,
   input  logic [HDATA_SIZE-1:0] HWDATA,
   output logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [1:0]            HTRANS,
   output logic                  HREADYOUT,
   input  logic                  HREADY,
   output logic                  HRESP
);

   localparam int AW    = $clog2(MEM_SIZE);
   localparam int WORDS = MEM_SIZE / 4;

   logic [HDATA_SIZE-1:0] mem [WORDS];

   logic          valid_q, valid_d;
   logic          write_q, write_d;
   logic [2:0]    size_q,  size_d;
   logic [AW-1:0] addr_q,  addr_d;

   logic [3:0]    be;
   logic [AW-3:0] widx;
   logic          accept;

   // Burst type, protection and address bits above the memory are don't-care.
   logic unused_inputs;
   assign unused_inputs = ^{HBURST, HPROT, HADDR[HADDR_SIZE-1:AW]};

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;

   // NONSEQ and SEQ (HTRANS[1] set) are the only transfers that start an access.
   assign accept = HSEL & HREADY & HTRANS[1];
   assign widx   = addr_q[AW-1:2];

   // Next data-phase context from the current address phase.
   always_comb begin
      valid_d = accept;
      write_d = 1'b0;
      size_d  = '0;
      addr_d  = '0;
      if (accept) begin
         write_d = HWRITE;
         size_d  = HSIZE;
         addr_d  = HADDR[AW-1:0];
      end
   end

   // Data-phase register with synchronous active-low reset.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         valid_q <= 1'b0;
         write_q <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         write_q <= write_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
      end
   end

   // Little-endian lane enables from registered size and low address bits.
   always_comb begin
      be = 4'b0000;
      case (size_q)
         3'd0:    be[addr_q[1:0]] = 1'b1;
         3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   // Commit enabled lanes of HWDATA in a write data phase.
   always_ff @(posedge HCLK) begin
      if (valid_q && write_q && HREADY) begin
         for (int unsigned n = 0; n < 4; n++) begin
            if (be[n]) mem[widx][8*n +: 8] <= HWDATA[8*n +: 8];
         end
      end
   end

   // Full word is returned combinationally during a read data phase.
   always_comb begin
      HRDATA = '0;
      if (valid_q && !write_q) HRDATA = mem[widx];
   end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench for ahb3lite_sram_slave with a byte-array bus model.
module tb_ahb3lite_sram_slave;

   localparam int MEM_SIZE = 4096;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic        HREADYOUT;
   logic        HREADY;
   logic        HRESP;

   int checks   = 0;
   int failures = 0;

   ahb3lite_sram_slave #(.MEM_SIZE(MEM_SIZE), .HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HREADYOUT(HREADYOUT),
      .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 HCLK = ~HCLK;

   // ---------------- bus model ----------------
   byte unsigned m_mem [MEM_SIZE];
   bit           m_valid;
   bit           m_write;
   int unsigned  m_addr;
   int unsigned  m_size;
   bit           m_rst_seen = 1'b0;

   function automatic int unsigned lane_count(int unsigned sz);
      return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_rdata();
      logic [31:0] w;
      int unsigned base;
      w = 32'h0;
      if (m_valid && !m_write) begin
         base = m_addr - (m_addr % 4);
         for (int i = 0; i < 4; i++) w[8*i +: 8] = m_mem[base + i];
      end
      return w;
   endfunction

   always @(posedge HCLK) begin
      int unsigned n, base, off;
      if (m_valid && m_write && HREADY) begin
         n    = lane_count(m_size);
         base = m_addr - (m_addr % n);
         for (int unsigned i = 0; i < n; i++) begin
            off = (base + i) % 4;
            m_mem[base + i] = HWDATA[8*off +: 8];
         end
      end
      if (!HRESETn) begin
         m_valid    = 1'b0;
         m_rst_seen = 1'b1;
      end else begin
         m_valid = HSEL && HREADY && (HTRANS == 2'd2 || HTRANS == 2'd3);
         m_write = HWRITE;
         m_addr  = HADDR % MEM_SIZE;
         m_size  = HSIZE;
      end
   end

   // Every-cycle comparison against the model, away from the clock edge.
   always @(negedge HCLK) begin
      if (m_rst_seen) begin
         checks++;
         if (HRDATA !== model_rdata()) begin
            failures++;
            $display("FAIL model_hrdata t=%0t got=%08h exp=%08h", $time, HRDATA, model_rdata());
         end
         checks++;
         if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            failures++;
            $display("FAIL ready_resp t=%0t got=%b/%b exp=1/0", $time, HREADYOUT, HRESP);
         end
      end
   end

   // ---------------- stimulus ----------------
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSEQ = 2'd2, SEQ = 2'd3;

   // One bus cycle: address phase of this beat, data of the previous beat.
   task automatic beat(input logic [1:0] tr, input logic sel, input logic rdy,
                       input logic wr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
      HTRANS = tr; HSEL = sel; HREADY = rdy; HWRITE = wr; HSIZE = sz;
      HADDR = a; HWDATA = wd;
      HBURST = 3'($urandom_range(0, 7));
      HPROT  = 4'($urandom_range(0, 15));
      @(posedge HCLK);
      #1;
   endtask

   // Literal expectation on HRDATA in the current data phase.
   task automatic lit(input string name, input logic [31:0] exp);
      #3;
      checks++;
      if (HRDATA !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", name, HRDATA, exp);
      end
   endtask

   initial begin
      HRESETn = 1'b0;
      HSEL = 0; HADDR = 0; HWDATA = 0; HWRITE = 0; HSIZE = 0;
      HBURST = 0; HPROT = 0; HTRANS = IDLE; HREADY = 1;
      @(posedge HCLK); #1;
      beat(IDLE, 0, 1, 0, 2, 0, 0);
      lit("reset_hrdata", 32'h0);
      HRESETn = 1'b1;
      beat(IDLE, 0, 1, 0, 2, 0, 0);

      // word write then read
      beat(NSEQ, 1, 1, 1, 2, 32'h10, 0);
      beat(NSEQ, 1, 1, 0, 2, 32'h10, 32'hDEADBEEF);
      lit("word_rd_0x10", 32'hDEADBEEF);
      beat(IDLE, 1, 1, 0, 2, 0, 0);
      lit("idle_hrdata", 32'h0);

      // byte and halfword lane writes, then byte-size read returns whole word
      beat(NSEQ, 1, 1, 1, 2, 32'h20, 0);
      beat(NSEQ, 1, 1, 1, 0, 32'h21, 32'h0);
      beat(NSEQ, 1, 1, 1, 0, 32'h23, 32'h0000AA00);
      beat(NSEQ, 1, 1, 1, 1, 32'h22, 32'h55000000);
      beat(NSEQ, 1, 1, 0, 0, 32'h21, 32'h12340000);
      lit("lanes_rd_0x20", 32'h1234AA00);
      beat(IDLE, 1, 1, 0, 2, 0, 0);

      // non-accepted transfers must not write
      beat(NSEQ, 1, 1, 1, 2, 32'h30, 0);
      beat(IDLE, 1, 1, 1, 2, 32'h30, 32'hCAFEF00D);
      beat(BUSY, 1, 1, 1, 2, 32'h30, 32'h11111111);
      beat(NSEQ, 0, 1, 1, 2, 32'h30, 32'h11111111);
      beat(NSEQ, 1, 0, 1, 2, 32'h30, 32'h11111111);
      beat(NSEQ, 1, 1, 0, 2, 32'h30, 32'h11111111);
      lit("noacc_rd_0x30", 32'hCAFEF00D);
      beat(IDLE, 1, 1, 0, 2, 0, 0);

      // INCR4 write and read, back to back
      beat(NSEQ, 1, 1, 1, 2, 32'h40, 0);
      beat(SEQ,  1, 1, 1, 2, 32'h44, 32'h1);
      beat(SEQ,  1, 1, 1, 2, 32'h48, 32'h2);
      beat(SEQ,  1, 1, 1, 2, 32'h4C, 32'h3);
      beat(NSEQ, 1, 1, 0, 2, 32'h40, 32'h4);
      lit("burst_rd0", 32'h1);
      beat(SEQ,  1, 1, 0, 2, 32'h44, 0);
      lit("burst_rd1", 32'h2);
      beat(SEQ,  1, 1, 0, 2, 32'h48, 0);
      lit("burst_rd2", 32'h3);
      beat(SEQ,  1, 1, 0, 2, 32'h4C, 0);
      lit("burst_rd3", 32'h4);
      beat(IDLE, 1, 1, 0, 2, 0, 0);

      // read immediately after write to same word
      beat(NSEQ, 1, 1, 1, 2, 32'h50, 0);
      beat(NSEQ, 1, 1, 0, 2, 32'h50, 32'hA5A5A5A5);
      lit("raw_rd_0x50", 32'hA5A5A5A5);

      // HSIZE=3 behaves as word; low address bits ignored
      beat(NSEQ, 1, 1, 1, 3, 32'h57, 0);
      beat(NSEQ, 1, 1, 0, 2, 32'h54, 32'h01020304);
      lit("size3_rd_0x54", 32'h01020304);

      // address wraps modulo MEM_SIZE
      beat(NSEQ, 1, 1, 1, 2, MEM_SIZE + 32'h8, 0);
      beat(NSEQ, 1, 1, 0, 2, 32'h8, 32'h600DF00D);
      lit("wrap_rd_0x8", 32'h600DF00D);
      beat(IDLE, 1, 1, 0, 2, 0, 0);
      lit("final_idle", 32'h0);
      beat(IDLE, 0, 1, 0, 2, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
- AMBA AHB3-Lite slave wrapping a single-port, byte-addressable on-chip SRAM.
- Sits on the AHB-Lite bus behind the address decoder and the HREADY/HRDATA multiplexer.
- Supports byte, halfword and word reads and writes; single, SEQ and burst transfers.
- Zero wait states; always returns OKAY.

Parameters:
- MEM_SIZE, 4096, memory size in bytes (power of 2, at least 4).
- HADDR_SIZE, 32, HADDR width.
- HDATA_SIZE, 32, HWDATA/HRDATA width (only 32 supported).

Ports:
- HCLK  in  1  bus clock; all state changes on its rising edge.
- HRESETn  in  1  reset; synchronous, active-low.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  HADDR_SIZE  byte address (address phase).
- HWDATA  in  HDATA_SIZE  write data (data phase).
- HRDATA  out  HDATA_SIZE  read data (data phase).
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word.
- HBURST  in  3  burst type; ignored.
- HPROT  in  4  protection; ignored.
- HTRANS  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- HREADYOUT  out  1  slave ready; constant 1.
- HREADY  in  1  bus ready from the mux; qualifies address-phase sampling.
- HRESP  out  1  response; constant 0 (OKAY).

Behaviour:
Reset (HRESETn = 0 at a rising edge):
- Clears the data-phase registers: valid, write, size, address.
- HRDATA = 0 while no read data phase is active.
- HREADYOUT = 1 and HRESP = 0 at all times, including during reset.
- Memory contents are not reset. Benches write a location before reading it.

Address-phase acceptance:
- A transfer is accepted at a rising edge when HSEL = 1, HREADY = 1 and HTRANS is NONSEQ or SEQ.
- On acceptance, register: valid = 1, HWRITE, HSIZE, HADDR[log2(MEM_SIZE)-1:0].
- Otherwise valid = 0. This covers IDLE, BUSY, HSEL = 0 and HREADY = 0; no memory access, no error.

Address decoding:
- Upper address bits beyond MEM_SIZE are ignored, so accesses wrap modulo MEM_SIZE.
- Word index = addr[log2(MEM_SIZE)-1:2].

Byte enables (little-endian lane mapping), from registered size and address:
- Byte: lane addr[1:0].
- Halfword: lanes {addr[1],0} and {addr[1],1}; addr[0] is ignored.
- Word (or HSIZE ≥ 2): all four lanes; addr[1:0] are ignored.
- Lane n = HWDATA/HRDATA bits [8n+7:8n].

Write:
- In the data phase (valid = 1, write = 1), the enabled lanes of HWDATA are written into the word at the rising edge where HREADY = 1.
- Disabled lanes are unchanged.

Read:
- In the data phase (valid = 1, write = 0), HRDATA = full memory word at the registered word index, driven combinationally from the array.
- All four lanes are returned regardless of HSIZE.
- Outside a read data phase, HRDATA = 0.

Latency and pipelining:
- Zero wait states: data phase is the cycle immediately after acceptance.
- Back-to-back NONSEQ/SEQ transfers run every cycle.
- Read directly after a write to the same word returns the newly written data, because the write commits at the edge that begins the read's data phase.

Bursts:
- No internal address generation; each beat uses the master-supplied HADDR.
- INCR, WRAP4/8/16 and SEQ beats are handled identically to NONSEQ.
- A BUSY beat inserted in a burst performs no access.

Test Plan:
- Reset, then word write 0xDEADBEEF @0x10, then word read @0x10 -> HRDATA = 0xDEADBEEF one cycle after the read address phase; HREADYOUT = 1, HRESP = 0 throughout.
- Word write 0x00000000 @0x20; byte writes 0xAA @0x21 and 0x55 @0x23; halfword write 0x1234 @0x22 -> word read @0x20 = 0x1234AA00.
- Write 0x11111111 @0x30 with HTRANS = IDLE, then BUSY, then with HSEL = 0, then with HREADY = 0 -> read @0x30 returns its prior value 0xCAFEF00D (pre-written).
- SEQ INCR4 write 0x1, 0x2, 0x3, 0x4 to 0x40–0x4C, then SEQ INCR4 read -> HRDATA 0x1, 0x2, 0x3, 0x4 on four consecutive cycles, no wait states.
- Write 0xA5A5A5A5 @0x50 and in the next cycle read @0x50 -> HRDATA = 0xA5A5A5A5.
- Write @(MEM_SIZE + 0x8) -> read @0x8 returns the written data (address wrap); randomized HPROT/HBURST values have no effect.
